// File: rtl/neopix_frame_scheduler_if.sv
// Pixel-fetch and serializer-stream bundle shared by the frame scheduler,
// the per-string frame stores and the WS2812 serializer.
interface neopix_frame_scheduler_if #(
    parameter int CW = 1,
    parameter int AW = 3
) ();
    logic          rd_en;
    logic [CW-1:0] rd_ch;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data;
    logic [23:0]   pix_data;
    logic          pix_valid;
    logic          pix_last;
    logic          pix_ready;
    logic          ser_busy;

    modport master (
        output rd_en, rd_ch, rd_addr,
        input  rd_data,
        output pix_data, pix_valid, pix_last,
        input  pix_ready, ser_busy
    );

    modport slave (
        input  rd_en, rd_ch, rd_addr,
        output rd_data,
        input  pix_data, pix_valid, pix_last,
        output pix_ready, ser_busy
    );
endinterface

// File: rtl/neopix_frame_scheduler.sv
// Round-robin scheduler sharing one WS2812 serializer among NUM_CH LED strings:
// grants a string, streams its NUM_LEDS pixels, waits for drain, then holds the latch gap.
module neopix_frame_scheduler #(
    parameter int  NUM_CH       = 2,
    parameter int  NUM_LEDS     = 8,
    parameter int  LATCH_CYCLES = 3000,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        done,
    output logic                     busy,
    neopix_frame_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_PUSH,
        ST_DRAIN,
        ST_LATCH
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_LEDS - 1);
    localparam logic [LW-1:0] LATCH_LOAD = LW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] LAST_CH    = CW'(NUM_CH - 1);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [CW-1:0]     last_gnt_q, last_gnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [23:0]       pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              pix_last_q, pix_last_d;
    logic [CW:0]       pick;

    // Nearest set request after 'last', wrapping; 'last' itself has lowest priority.
    // Result MSB flags that any request was found.
    function automatic logic [CW:0] rr_pick(input logic [NUM_CH-1:0] r,
                                            input logic [CW-1:0]     last);
        logic [CW:0]   res;
        logic [CW-1:0] idx;
        res = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = CW'((int'(last) + i) % NUM_CH);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign pick = rr_pick(req, last_gnt_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        ch_d        = ch_q;
        last_gnt_d  = last_gnt_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick[CW]) begin
                    gnt_d   = NUM_CH'(1) << pick[CW-1:0];
                    ch_d    = pick[CW-1:0];
                    addr_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                pix_data_d  = bus.rd_data;
                pix_valid_d = 1'b1;
                pix_last_d  = (addr_q == LAST_ADDR);
                state_d     = ST_PUSH;
            end
            ST_PUSH: begin
                if (bus.pix_ready) begin
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                    if (pix_last_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DRAIN: begin
                if (!bus.ser_busy) begin
                    cnt_d   = LATCH_LOAD;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // Grant is held through the gap so the DO mux keeps the line low on this string.
                if (cnt_q == '0) begin
                    done_d     = gnt_q;
                    gnt_d      = '0;
                    last_gnt_d = ch_q;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            ch_q        <= '0;
            last_gnt_q  <= LAST_CH;
            addr_q      <= '0;
            cnt_q       <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            ch_q        <= ch_d;
            last_gnt_q  <= last_gnt_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE);
    assign bus.rd_en     = (state_q == ST_READ);
    assign bus.rd_ch     = ch_q;
    assign bus.rd_addr   = addr_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_last  = pix_last_q;
endmodule

// File: tb/tb_neopix_frame_scheduler.sv
// Self-checking bench for neopix_frame_scheduler: random pixel stores, ready stalls,
// serializer drain times and request patterns against a frame-level reference model.
module tb_neopix_frame_scheduler;
    localparam int NUM_CH       = 2;
    localparam int NUM_LEDS     = 8;
    localparam int LATCH_CYCLES = 3000;
    localparam int CW           = 1;
    localparam int AW           = 3;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] done;
    logic              busy;

    neopix_frame_scheduler_if #(.CW(CW), .AW(AW)) bus ();

    neopix_frame_scheduler #(
        .NUM_CH      (NUM_CH),
        .NUM_LEDS    (NUM_LEDS),
        .LATCH_CYCLES(LATCH_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int model_last;
    logic [23:0] mem [NUM_CH][NUM_LEDS];

    // Frame store: data for a strobed address appears one cycle after the strobe, junk otherwise.
    initial begin : frame_store
        logic          pend;
        logic [CW-1:0] pch;
        logic [AW-1:0] paddr;
        pend = 1'b0;
        pch = '0;
        paddr = '0;
        bus.rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend) bus.rd_data = mem[pch][paddr];
            else bus.rd_data = 24'($urandom);
            pend  = bus.rd_en;
            pch   = bus.rd_ch;
            paddr = bus.rd_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first requesting string after the previous winner, wrapping.
    function automatic int rr_model(input logic [NUM_CH-1:0] r, input int last);
        for (int k = 1; k <= NUM_CH; k++) begin
            if (r[CW'((last + k) % NUM_CH)]) return (last + k) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic bit all_out_zero();
        return (gnt == '0) && (done == '0) && !busy && !bus.rd_en && (bus.rd_ch == '0) &&
               (bus.rd_addr == '0) && (bus.pix_data == '0) && !bus.pix_valid && !bus.pix_last;
    endfunction

    task automatic fill_mem();
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < NUM_LEDS; a++)
                mem[c][a] = 24'($urandom);
    endtask

    task automatic do_reset();
        req = '0;
        bus.pix_ready = 1'b0;
        bus.ser_busy = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        model_last = NUM_CH - 1;
    endtask

    // Serves one whole frame on string ch and checks it end to end.
    // mode 0: always ready, 1: random ready, 2: stall pixel stall_pix for stall_len cycles.
    // blen: cycles the serializer stays busy after the final handshake.
    task automatic serve_frame(input int ch, input int mode, input int stall_pix,
                               input int stall_len, input int blen, input bit scramble);
        int t, pix, h_t, exp_done, stall_cnt, rd_cnt, tries, bad_hold, unstable;
        bit fin, hold_prev;
        logic [23:0] prev_data;
        logic prev_last, exp_last;
        logic [NUM_CH-1:0] exp_g;
        exp_g = '0;
        exp_g[ch] = 1'b1;
        tries = 0;
        while (gnt === '0 && tries < 20) begin
            tick();
            tries++;
        end
        checks++;
        if (gnt !== exp_g) begin
            failures++;
            $display("FAIL grant: actual=%b required=%b", gnt, exp_g);
        end
        model_last = ch;
        t = 0; pix = 0; h_t = -1; exp_done = -1; stall_cnt = 0; rd_cnt = 0;
        bad_hold = 0; unstable = 0; fin = 1'b0; hold_prev = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        while (!fin && t < 8000) begin
            if (scramble) req = NUM_CH'($urandom);
            if (h_t < 0) bus.ser_busy = (blen > 0);
            else bus.ser_busy = (t < h_t + blen);
            case (mode)
                0: bus.pix_ready = 1'b1;
                1: bus.pix_ready = 1'($urandom_range(0, 1));
                default: begin
                    bus.pix_ready = !(bus.pix_valid && pix == stall_pix && stall_cnt < stall_len);
                    if (bus.pix_valid && pix == stall_pix) stall_cnt++;
                end
            endcase
            if (hold_prev && {bus.pix_valid, bus.pix_data, bus.pix_last} !== {1'b1, prev_data, prev_last})
                unstable++;
            if (bus.rd_en) begin
                rd_cnt++;
                checks++;
                if ({bus.rd_ch, bus.rd_addr, bus.pix_valid} !== {CW'(ch), AW'(pix), 1'b0}) begin
                    failures++;
                    $display("FAIL read_strobe: ch/addr/pix_valid actual=%0d/%0d/%b required=%0d/%0d/0",
                             bus.rd_ch, bus.rd_addr, bus.pix_valid, ch, pix);
                end
            end
            hold_prev = 1'b0;
            if (bus.pix_valid === 1'b1 && pix < NUM_LEDS) begin
                if (bus.pix_ready) begin
                    exp_last = (pix == NUM_LEDS - 1);
                    checks++;
                    if ({bus.pix_data, bus.pix_last} !== {mem[ch][pix], exp_last}) begin
                        failures++;
                        $display("FAIL pixel %0d: data/last actual=%h/%b required=%h/%b",
                                 pix, bus.pix_data, bus.pix_last, mem[ch][pix], exp_last);
                    end
                    if (exp_last) begin
                        h_t = t + 1;
                        exp_done = h_t + blen + 1 + LATCH_CYCLES;
                    end
                    pix++;
                end else begin
                    hold_prev = 1'b1;
                    prev_data = bus.pix_data;
                    prev_last = bus.pix_last;
                end
            end else if (bus.pix_valid !== 1'b0) begin
                bad_hold++;
            end
            if (done !== '0) begin
                fin = 1'b1;
                checks++;
                if (t != exp_done || {done, gnt, busy} !== {exp_g, {NUM_CH{1'b0}}, 1'b0}) begin
                    failures++;
                    $display("FAIL done_pulse: cycle=%0d done=%b gnt=%b busy=%b required cycle=%0d done=%b gnt=0 busy=0",
                             t, done, gnt, busy, exp_done, exp_g);
                end
            end else if ({gnt, busy} !== {exp_g, 1'b1}) begin
                bad_hold++;
            end
            if (!fin) begin
                tick();
                t++;
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: ch=%0d handshakes=%0d", ch, pix);
        end
        checks++;
        if (rd_cnt != NUM_LEDS || pix != NUM_LEDS) begin
            failures++;
            $display("FAIL frame_count: reads=%0d handshakes=%0d required=%0d each", rd_cnt, pix, NUM_LEDS);
        end
        checks++;
        if (bad_hold != 0 || unstable != 0) begin
            failures++;
            $display("FAIL frame_hold: bad_cycles=%0d unstable_cycles=%0d required=0/0", bad_hold, unstable);
        end
    endtask

    task automatic test_reset();
        req = '0;
        bus.pix_ready = 1'b0;
        bus.ser_busy = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++;
        if (!all_out_zero()) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b done=%b busy=%b rd_en=%b pix_valid=%b required all 0",
                     gnt, done, busy, bus.rd_en, bus.pix_valid);
        end
        rst_n = 1'b1;
        model_last = NUM_CH - 1;
        repeat (5) tick();
        checks++;
        if ({gnt, busy, bus.rd_en} !== '0) begin
            failures++;
            $display("FAIL idle_no_req: gnt=%b busy=%b rd_en=%b required 0", gnt, busy, bus.rd_en);
        end
    endtask

    task automatic test_single_frame();
        int ch;
        do_reset();
        fill_mem();
        req = 2'b01;
        ch = rr_model(req, model_last);
        serve_frame(ch, 0, 0, 0, 0, 1'b0);
        req = '0;
        tick();
        checks++;
        if ({busy, gnt, done} !== '0) begin
            failures++;
            $display("FAIL after_done: busy=%b gnt=%b done=%b required 0", busy, gnt, done);
        end
    endtask

    task automatic test_round_robin();
        int ch;
        do_reset();
        fill_mem();
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            ch = rr_model(req, model_last);
            serve_frame(ch, 1, 0, 0, int'($urandom_range(0, 10)), 1'b0);
        end
        req = '0;
        tick();
    endtask

    task automatic test_ready_stall();
        do_reset();
        fill_mem();
        req = 2'b01;
        serve_frame(rr_model(req, model_last), 2, 3, 50, 0, 1'b0);
        req = '0;
        tick();
    endtask

    task automatic test_ser_busy();
        do_reset();
        fill_mem();
        req = 2'b10;
        serve_frame(rr_model(req, model_last), 0, 0, 0, 100, 1'b0);
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int hs, tries;
        do_reset();
        fill_mem();
        req = 2'b01;
        bus.pix_ready = 1'b1;
        hs = 0;
        tries = 0;
        while (!(bus.pix_valid && hs == 4) && tries < 200) begin
            if (bus.pix_valid && bus.pix_ready) hs++;
            tick();
            tries++;
        end
        checks++;
        if (!(bus.pix_valid && busy)) begin
            failures++;
            $display("FAIL reach_pixel4: pix_valid=%b busy=%b required 1/1", bus.pix_valid, busy);
        end
        bus.pix_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!all_out_zero()) begin
            failures++;
            $display("FAIL abort_outputs: gnt=%b done=%b busy=%b rd_en=%b pix_valid=%b pix_last=%b required all 0",
                     gnt, done, busy, bus.rd_en, bus.pix_valid, bus.pix_last);
        end
        req = 2'b11;
        tick();
        tick();
        rst_n = 1'b1;
        model_last = NUM_CH - 1;
        serve_frame(rr_model(req, model_last), 0, 0, 0, 0, 1'b0);
        req = '0;
        tick();
    endtask

    task automatic test_req_pulse();
        int ch;
        do_reset();
        fill_mem();
        req = 2'b10;
        ch = rr_model(req, model_last);
        tick();
        req = '0;
        serve_frame(ch, 0, 0, 0, 0, 1'b0);
        tick();
        checks++;
        if ({busy, gnt} !== '0) begin
            failures++;
            $display("FAIL pulse_no_regrant: busy=%b gnt=%b required 0", busy, gnt);
        end
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] r;
        fill_mem();
        for (int f = 0; f < 6; f++) begin
            r = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            req = r;
            serve_frame(rr_model(r, model_last), 1, 0, 0, int'($urandom_range(0, 30)), 1'b1);
        end
        req = '0;
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        req = '0;
        bus.pix_ready = 1'b0;
        bus.ser_busy = 1'b0;
        model_last = NUM_CH - 1;
        #3;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_ready_stall();
        test_ser_busy();
        test_reset_mid_frame();
        test_req_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
